int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_pkg.sv | 30 +++
 rtl/irq_edge.sv | 57 +++++
 rtl/int_ctrl.sv | 134 +++++++++++++
 tb/tb_int_ctrl.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, CP0 Status/Cause
// field positions, the interrupt ExcCode and the default handler vector.
package int_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 10;

  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  localparam logic [4:0]  EXC_INT        = 5'd0;
  localparam logic [31:0] DEFAULT_VECTOR = 32'h0000_0180;

  // Status image written on entry: same as the live value with EXL forced on.
  function automatic logic [31:0] set_exl(input logic [31:0] st);
    logic [31:0] mask;
    mask             = '0;
    mask[STATUS_EXL] = 1'b1;
    return st | mask;
  endfunction

endpackage

// File: rtl/irq_edge.sv
// Rising-edge detector for the hardware interrupt lines. Defining IRQ_SYNC_EN
// inserts a 2-flop synchronizer per line ahead of the edge detector.
module irq_edge #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] sampled;
  logic [WIDTH-1:0] prev_d;
  logic [WIDTH-1:0] prev_q;

`ifdef IRQ_SYNC_EN
  logic [WIDTH-1:0] sync1_d;
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_d;
  logic [WIDTH-1:0] sync2_q;

  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = irq_in;
`endif

  always_comb begin
    prev_d = sampled;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  // A line held high produces exactly one pulse here.
  assign rise = sampled & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches irq edges as pending, picks the highest-index
// unmasked line and issues a one-cycle CP0 write + fetch redirect. IRQ_SYNC_EN
// adds a 2-flop input synchronizer (inside irq_edge).
module int_ctrl
  import int_pkg::*;
#(
  parameter int          NIRQ   = 6,
  parameter logic [31:0] VECTOR = DEFAULT_VECTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NIRQ-1:0] irq,
  input  logic [31:0]     status,
  input  logic [31:0]     pc_cur,
  input  logic            eret,
  output logic            INT,
  output logic [31:0]     wepc,
  output logic [31:0]     wcause,
  output logic [31:0]     wstatus,
  output logic            redirect,
  output logic [31:0]     vector_pc,
  output logic            busy
);

  state_e          state_d;
  state_e          state_q;
  logic [NIRQ-1:0] pending_d;
  logic [NIRQ-1:0] pending_q;
  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] req;
  logic [NIRQ-1:0] winner;
  logic            ie_ok;
  logic [31:0]     cause_val;

  logic            int_d;
  logic            int_q;
  logic            redirect_d;
  logic            redirect_q;
  logic [31:0]     wepc_d;
  logic [31:0]     wepc_q;
  logic [31:0]     wcause_d;
  logic [31:0]     wcause_q;
  logic [31:0]     wstatus_d;
  logic [31:0]     wstatus_q;

  irq_edge #(
    .WIDTH(NIRQ)
  ) u_irq_edge (
    .clk   (clk),
    .rst   (rst),
    .irq_in(irq),
    .rise  (rise)
  );

  // Request gating and highest-index priority pick; Cause reports every pending line.
  always_comb begin
    ie_ok  = status[STATUS_IE] & ~status[STATUS_EXL];
    req    = pending_q & status[STATUS_IM_LO +: NIRQ] & {NIRQ{ie_ok}};
    winner = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
    cause_val                             = '0;
    cause_val[CAUSE_IP_LO +: NIRQ]        = pending_q;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO]  = EXC_INT;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | rise;
    int_d      = 1'b0;
    redirect_d = 1'b0;
    wepc_d     = '0;
    wcause_d   = '0;
    wstatus_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d    = ST_TAKE;
          // Clear the winner first so a fresh edge on the same line survives.
          pending_d  = (pending_q & ~winner) | rise;
          int_d      = 1'b1;
          redirect_d = 1'b1;
          wepc_d     = pc_cur;
          wcause_d   = cause_val;
          wstatus_d  = set_exl(status);
        end
      end
      ST_TAKE: begin
        state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (eret) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      int_q      <= 1'b0;
      redirect_q <= 1'b0;
      wepc_q     <= '0;
      wcause_q   <= '0;
      wstatus_q  <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      int_q      <= int_d;
      redirect_q <= redirect_d;
      wepc_q     <= wepc_d;
      wcause_q   <= wcause_d;
      wstatus_q  <= wstatus_d;
    end
  end

  assign INT       = int_q;
  assign redirect  = redirect_q;
  assign wepc      = wepc_q;
  assign wcause    = wcause_q;
  assign wstatus   = wstatus_q;
  assign vector_pc = VECTOR;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the controller.
module tb_int_ctrl;

  localparam int NIRQ = 6;
`ifdef IRQ_SYNC_EN
  localparam int FIRST_INT = 4;
`else
  localparam int FIRST_INT = 2;
`endif

  logic            clk;
  logic            rst;
  logic [NIRQ-1:0] irq;
  logic [31:0]     status;
  logic [31:0]     pc_cur;
  logic            eret;
  logic            int_o;
  logic            redirect;
  logic            busy;
  logic [31:0]     wepc;
  logic [31:0]     wcause;
  logic [31:0]     wstatus;
  logic [31:0]     vector_pc;

  int checks   = 0;
  int failures = 0;

  int_ctrl #(
    .NIRQ  (NIRQ),
    .VECTOR(32'h0000_0180)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .status   (status),
    .pc_cur   (pc_cur),
    .eret     (eret),
    .INT      (int_o),
    .wepc     (wepc),
    .wcause   (wcause),
    .wstatus  (wstatus),
    .redirect (redirect),
    .vector_pc(vector_pc),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: pending lines, "announcing" (the one entry cycle) and
  // "in handler" (until eret), plus the values written on entry.
  logic [NIRQ-1:0] m_pend;
  logic [NIRQ-1:0] m_prev;
  logic [NIRQ-1:0] m_s1;
  logic [NIRQ-1:0] m_s2;
  logic            m_announce;
  logic            m_handler;
  logic [31:0]     m_wepc;
  logic [31:0]     m_wcause;
  logic [31:0]     m_wstatus;

  task automatic model_reset();
    m_pend     = '0;
    m_prev     = '0;
    m_s1       = '0;
    m_s2       = '0;
    m_announce = 1'b0;
    m_handler  = 1'b0;
    m_wepc     = '0;
    m_wcause   = '0;
    m_wstatus  = '0;
  endtask

  task automatic model_edge();
    logic [NIRQ-1:0] seen;
    logic [NIRQ-1:0] rises;
    logic [NIRQ-1:0] eligible;
    int              top;
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef IRQ_SYNC_EN
    seen = m_s2;
    m_s2 = m_s1;
    m_s1 = irq;
`else
    seen = irq;
`endif
    rises     = seen & ~m_prev;
    m_prev    = seen;
    eligible  = (status[0] && !status[1]) ? (m_pend & status[15:10]) : '0;
    m_wepc    = '0;
    m_wcause  = '0;
    m_wstatus = '0;
    if (m_announce) begin
      m_announce = 1'b0;
      m_handler  = 1'b1;
      m_pend     = m_pend | rises;
    end else if (m_handler) begin
      if (eret) m_handler = 1'b0;
      m_pend = m_pend | rises;
    end else if (eligible != 0) begin
      top = -1;
      for (int i = NIRQ - 1; i >= 0; i--) begin
        if (top < 0 && eligible[i]) top = i;
      end
      m_wepc      = pc_cur;
      m_wcause    = 32'(m_pend) * 32'd1024;
      m_wstatus   = status | 32'h2;
      m_pend[top] = 1'b0;
      m_pend      = m_pend | rises;
      m_announce  = 1'b1;
    end else begin
      m_pend = m_pend | rises;
    end
  endtask

  function automatic logic [98:0] observed();
    return {int_o, redirect, busy, wepc, wcause, wstatus};
  endfunction

  function automatic logic [98:0] expected();
    return {m_announce, m_announce, m_announce | m_handler, m_wepc, m_wcause, m_wstatus};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_int(input int max_cycles, output bit found);
    found = 1'b0;
    for (int n = 0; n < max_cycles && !found; n++) begin
      cycle();
      if (int_o === 1'b1) found = 1'b1;
    end
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    cycle();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h exp=0", observed());
    end
    checks++;
    if (vector_pc !== 32'h0000_0180) begin
      failures++;
      $display("[TB] FAIL vector_pc got=%h exp=00000180", vector_pc);
    end
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(3);
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("[TB] FAIL post_reset_idle got=%h exp=0", observed());
    end
  endtask

  task automatic test_single_irq();
    int first;
    int ints;
    logic [98:0] snap;
    snap   = '0;
    status = 32'h0000_0401;
    pc_cur = 32'h0040_0010;
    idle_cycles(2);
    irq[0] = 1'b1;
    first  = -1;
    ints   = 0;
    for (int n = 1; n <= 8; n++) begin
      cycle();
      if (int_o === 1'b1) begin
        ints++;
        if (first < 0) begin
          first = n;
          snap  = observed();
        end
      end
    end
    checks++;
    if (first != FIRST_INT) begin
      failures++;
      $display("[TB] FAIL single_latency got=%0d exp=%0d", first, FIRST_INT);
    end
    checks++;
    if (ints != 1) begin
      failures++;
      $display("[TB] FAIL single_int_count got=%0d exp=1", ints);
    end
    checks++;
    if (snap !== {1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h0000_0400, 32'h0000_0403}) begin
      failures++;
      $display("[TB] FAIL single_take_values got=%h exp=%h", snap,
               {1'b1, 1'b1, 1'b1, 32'h0040_0010, 32'h0000_0400, 32'h0000_0403});
    end
    checks++;
    if (busy !== 1'b1 || int_o !== 1'b0 || redirect !== 1'b0 || wepc !== 32'h0) begin
      failures++;
      $display("[TB] FAIL single_service got=%b%b%b exp=100", busy, int_o, redirect);
    end
    eret_pulse();
    irq = '0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_eret_idle got=%b exp=0", busy);
    end
    idle_cycles(3);
  endtask

  task automatic test_priority();
    bit found;
    status = 32'h0000_FC01;
    irq    = 6'b010010;
    wait_int(8, found);
    checks++;
    if (!found || wcause[15:10] !== 6'b010010) begin
      failures++;
      $display("[TB] FAIL prio_first_cause got=%b found=%0d exp=010010", wcause[15:10], found);
    end
    cycle();
    eret_pulse();
    wait_int(4, found);
    checks++;
    if (!found || wcause[15:10] !== 6'b000010) begin
      failures++;
      $display("[TB] FAIL prio_second_cause got=%b found=%0d exp=000010", wcause[15:10], found);
    end
    cycle();
    eret_pulse();
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_ie_gate();
    bit found;
    int ints;
    status = 32'h0000_FC00;
    irq[2] = 1'b1;
    ints   = 0;
    for (int n = 0; n < 8; n++) begin
      cycle();
      if (int_o === 1'b1) ints++;
    end
    checks++;
    if (ints != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ie_masked got=%0d busy=%b exp=0", ints, busy);
    end
    status = 32'h0000_FC01;
    wait_int(2, found);
    checks++;
    if (!found || wcause[15:10] !== 6'b000100) begin
      failures++;
      $display("[TB] FAIL ie_enable_take got=%0d cause=%b exp=1 000100", found, wcause[15:10]);
    end
    cycle();
    eret_pulse();
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_level_hold();
    int ints;
    status = 32'h0000_FC01;
    irq[3] = 1'b1;
    ints   = 0;
    for (int i = 0; i < 20; i++) begin
      eret = (i == 5);
      cycle();
      if (int_o === 1'b1) ints++;
    end
    eret = 1'b0;
    checks++;
    if (ints != 1) begin
      failures++;
      $display("[TB] FAIL level_hold_ints got=%0d exp=1", ints);
    end
    irq = '0;
    idle_cycles(3);
    eret_pulse();
    cycle();
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("[TB] FAIL eret_in_idle got=%h exp=0", observed());
    end
  endtask

  task automatic test_reset_in_service();
    bit found;
    int ints;
    status = 32'h0000_FC01;
    irq    = 6'b100000;
    wait_int(8, found);
    checks++;
    if (!found || wcause[15:10] !== 6'b100000) begin
      failures++;
      $display("[TB] FAIL rst_svc_take got=%0d cause=%b exp=1 100000", found, wcause[15:10]);
    end
    cycle();
    irq = 6'b100100;
    idle_cycles(3);
    checks++;
    if (busy !== 1'b1 || int_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_svc_hold got=%b%b exp=10", busy, int_o);
    end
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (observed() !== '0) begin
      failures++;
      $display("[TB] FAIL rst_immediate got=%h exp=0", observed());
    end
    irq = '0;
    idle_cycles(2);
    rst  = 1'b1;
    ints = 0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (int_o === 1'b1) ints++;
    end
    checks++;
    if (ints != 0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rst_no_int got=%0d busy=%b exp=0", ints, busy);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    status = 32'h0000_FC01;
    irq    = 6'b000001;
    wait_int(8, found);
    cycle();
    irq = 6'b000011;
    idle_cycles(3);
    eret = 1'b1;
    cycle();
    eret = 1'b0;
    checks++;
    if (busy !== 1'b0 || int_o !== 1'b0 || observed() !== expected()) begin
      failures++;
      $display("[TB] FAIL b2b_return got=%h exp=%h", observed(), expected());
    end
    cycle();
    checks++;
    if (int_o !== 1'b1 || wcause[15:10] !== 6'b000010 || observed() !== expected()) begin
      failures++;
      $display("[TB] FAIL b2b_retake got=%h exp=%h", observed(), expected());
    end
    cycle();
    eret_pulse();
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_random();
    logic [NIRQ-1:0] flip;
    for (int n = 0; n < 800; n++) begin
      flip = '0;
      for (int b = 0; b < NIRQ; b++) begin
        if ($urandom_range(7) == 0) flip[b] = 1'b1;
      end
      irq       = irq ^ flip;
      status    = $urandom();
      status[0] = ($urandom_range(7) != 0);
      status[1] = ($urandom_range(7) == 0);
      pc_cur    = $urandom();
      eret      = ($urandom_range(3) == 0);
      if ($urandom_range(149) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      cycle();
      checks++;
      if (observed() !== expected()) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d got=%h exp=%h", n, observed(), expected());
      end
    end
    rst  = 1'b1;
    eret = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst    = 1'b0;
    irq    = '0;
    status = '0;
    pc_cur = '0;
    eret   = 1'b0;
    model_reset();
    test_reset();
    test_single_irq();
    test_priority();
    test_ie_gate();
    test_level_hold();
    test_reset_in_service();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
